wsi_unpack: RTL

WSI_UNPACK -- requirements
Module: wsi_unpack

---
 rtl/wsi_unpack.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wsi_unpack.sv
// WSI width-down adapter: buffers IN_W words in a small FIFO and issues each one
// as LANES left-justified SAMP_W samples, one per OUT_W output word.
module wsi_unpack #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned SAMP_W    = 16,
  parameter int unsigned OUT_W     = 18,
  parameter int unsigned DEPTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              ctl_Clk,
  input  logic              ctl_MReset_n,
  input  logic [2:0]        in_MCmd,
  input  logic              in_MReqLast,
  input  logic              in_MBurstPrecise,
  input  logic [11:0]       in_MBurstLength,
  input  logic [IN_W-1:0]   in_MData,
  input  logic              in_MReqInfo,
  output logic              in_SThreadBusy,
  output logic [2:0]        out_MCmd,
  output logic              out_MReqLast,
  output logic              out_MBurstPrecise,
  output logic [11:0]       out_MBurstLength,
  output logic [OUT_W-1:0]  out_MData,
  output logic              out_MReqInfo,
  input  logic              out_SThreadBusy,
  input  logic              clr,
  output logic              overflow
);

  localparam int unsigned LANES = IN_W / SAMP_W;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam logic [2:0]  CMD_IDLE  = 3'b000;
  localparam logic [2:0]  CMD_WRITE = 3'b001;

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [IN_W-1:0]     r_mem_data [DEPTH];
  logic                r_mem_last [DEPTH];
  logic                r_mem_prec [DEPTH];
  logic [11:0]         r_mem_len  [DEPTH];
  logic                r_mem_info [DEPTH];

  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [LW-1:0]       r_lane;
  logic                r_busy;
  logic                r_ovf;

  logic [2:0]          r_out_cmd;
  logic                r_out_last;
  logic                r_out_prec;
  logic [11:0]         r_out_len;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_info;

  logic                w_wr;
  logic                w_full;
  logic                w_issue;
  logic                w_lane_end;
  logic                w_pop;
  logic                w_push;
  logic                w_ovf;
  logic [CW-1:0]       w_count_nxt;
  logic [LW-1:0]       w_sel;
  logic [SAMP_W-1:0]   w_sample;
  logic [31:0]         w_prod;
  logic                w_prec;

  assign w_wr   = (in_MCmd == CMD_WRITE);
  assign w_full = (r_count == CW'(DEPTH));

  // State register
  always_ff @(posedge ctl_Clk or negedge ctl_MReset_n) begin
    if (!ctl_MReset_n) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Next state, issue/pop/push decisions; a pop frees the slot a same-cycle push needs
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_lane_end  = (r_lane == LW'(LANES - 1));
    case (r_state)
      S_IDLE:   w_issue = 1'b0;
      S_ACTIVE: w_issue = !out_SThreadBusy && (r_count != '0);
      default:  w_issue = 1'b0;
    endcase
    w_pop       = w_issue && w_lane_end;
    w_push      = w_wr && (!w_full || w_pop);
    w_ovf       = w_wr && w_full && !w_pop;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    case (r_state)
      S_IDLE:   if (r_count != '0) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_count_nxt == '0) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Lane select and output-length arithmetic for the head word
  always_comb begin
    w_sel    = LSB_FIRST ? r_lane : (LW'(LANES - 1) - r_lane);
    w_sample = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (w_sel == LW'(i)) w_sample = r_mem_data[r_rd_ptr][i*SAMP_W +: SAMP_W];
    end
    w_prod = 32'(r_mem_len[r_rd_ptr]) * 32'(LANES);
    w_prec = r_mem_prec[r_rd_ptr] && (w_prod <= 32'd4095);
  end

  always_ff @(posedge ctl_Clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= in_MData;
      r_mem_last[r_wr_ptr] <= in_MReqLast;
      r_mem_prec[r_wr_ptr] <= in_MBurstPrecise;
      r_mem_len[r_wr_ptr]  <= in_MBurstLength;
      r_mem_info[r_wr_ptr] <= in_MReqInfo;
    end
  end

  always_ff @(posedge ctl_Clk or negedge ctl_MReset_n) begin
    if (!ctl_MReset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lane     <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_out_cmd  <= CMD_IDLE;
      r_out_last <= 1'b0;
      r_out_prec <= 1'b0;
      r_out_len  <= '0;
      r_out_data <= '0;
      r_out_info <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      if (w_issue) r_lane <= w_lane_end ? '0 : r_lane + LW'(1);
      // One slot stays free to absorb the write already in flight when busy rises
      r_busy <= (w_count_nxt >= CW'(DEPTH - 1));
      if (w_ovf)    r_ovf <= 1'b1;
      else if (clr) r_ovf <= 1'b0;
      r_out_cmd  <= w_issue ? CMD_WRITE : CMD_IDLE;
      r_out_last <= w_issue && w_lane_end && r_mem_last[r_rd_ptr];
      r_out_prec <= w_issue && w_prec;
      r_out_len  <= (w_issue && w_prec) ? w_prod[11:0] : '0;
      r_out_data <= w_issue ? (OUT_W'(w_sample) << (OUT_W - SAMP_W)) : '0;
      r_out_info <= w_issue && r_mem_info[r_rd_ptr];
    end
  end

  assign in_SThreadBusy    = r_busy;
  assign overflow          = r_ovf;
  assign out_MCmd          = r_out_cmd;
  assign out_MReqLast      = r_out_last;
  assign out_MBurstPrecise = r_out_prec;
  assign out_MBurstLength  = r_out_len;
  assign out_MData         = r_out_data;
  assign out_MReqInfo      = r_out_info;

endmodule
